// File: rtl/music_pkg.sv
// Shared types and constants for the music_player score sequencer:
// FSM state, octave selector, note field offsets and pitch tables.
package music_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_GAP,
    ST_FINISH
  } state_e;

  typedef enum logic [1:0] {
    OCT_LOW,
    OCT_MED,
    OCT_HIGH
  } octave_e;

  localparam int TONE_W   = 20;
  localparam int NIB_W    = 4;
  localparam int HIGH_LSB = 8;
  localparam int MED_LSB  = 4;
  localparam int LOW_LSB  = 0;

  // Pitch in Hz for scale degrees 1..7 of each octave.
  localparam int FREQ_LOW  [7] = '{262, 294, 330, 349, 392, 440, 494};
  localparam int FREQ_MED  [7] = '{523, 587, 659, 698, 784, 880, 988};
  localparam int FREQ_HIGH [7] = '{1047, 1175, 1319, 1397, 1568, 1760, 1976};

  // Only ever called with constant arguments, so it folds at elaboration.
  function automatic logic [TONE_W-1:0] half_period(input int clk_freq, input int f);
    return TONE_W'(clk_freq / (2 * f));
  endfunction

endpackage

// File: rtl/music_player_tone_gen.sv
// Square-wave generator: half-period counter plus toggle flop. The output is
// the toggle flop's next value so the parent can register it with gating.
module tone_gen
  import music_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [TONE_W-1:0] half,
  output logic              buzzer
);

  logic [TONE_W-1:0] cnt_q, cnt_d;
  logic              tog_q, tog_d;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    tog_d = tog_q;
    if (clr) begin
      cnt_d = '0;
      tog_d = 1'b0;
    end else if (en) begin
      if (cnt_q == half - TONE_W'(1)) begin
        cnt_d = '0;
        tog_d = ~tog_q;
      end else begin
        cnt_d = cnt_q + TONE_W'(1);
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tog_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tog_q <= tog_d;
    end
  end

  assign buzzer = tog_d;

endmodule

// File: rtl/music_player.sv
// Score sequencer: walks the note ROM, holds each note for one beat with a
// trailing silent gap, and drives the buzzer. MUSIC_PLAYER_TEMPO_EN adds a
// 2-bit tempo input that halves or doubles the slot length.
module music_player
  import music_pkg::*;
#(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BEAT_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 2_000_000,
  parameter int ROM_DEPTH   = 96,
  parameter int ADDR_WIDTH  = 7,
  parameter int ROM_WIDTH   = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic                  loop_en,
`ifdef MUSIC_PLAYER_TEMPO_EN
  input  logic [1:0]            tempo,
`endif
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [ROM_WIDTH-1:0]  rom_data,
  output logic [ROM_WIDTH-1:0]  note_code,
  output logic                  buzzer,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = $clog2(2 * BEAT_CYCLES + 1);
  localparam logic [CNT_W-1:0] PLAY_LEN = CNT_W'(BEAT_CYCLES - GAP_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LEN  = CNT_W'(GAP_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ROM_DEPTH - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [ROM_WIDTH-1:0]  note_code_q, note_code_d;
  logic                  buzzer_q, buzzer_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [CNT_W-1:0]      play_len, gap_len;

`ifdef MUSIC_PLAYER_TEMPO_EN
  localparam int GAP_FAST_I = (GAP_CYCLES / 2 > 0) ? GAP_CYCLES / 2 : 1;
  localparam logic [CNT_W-1:0] GAP_FAST  = CNT_W'(GAP_FAST_I);
  localparam logic [CNT_W-1:0] PLAY_FAST = CNT_W'(BEAT_CYCLES / 2 - GAP_FAST_I);
  localparam logic [CNT_W-1:0] GAP_SLOW  = CNT_W'(GAP_CYCLES * 2);
  localparam logic [CNT_W-1:0] PLAY_SLOW = CNT_W'((BEAT_CYCLES - GAP_CYCLES) * 2);

  logic [1:0] tempo_q, tempo_d;

  // Tempo is captured as the note loads and holds for the whole slot.
  always_comb begin
    tempo_d = tempo_q;
    if (state_q == ST_LOAD && !pause && !stop) tempo_d = tempo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tempo_q <= 2'b00;
    else        tempo_q <= tempo_d;
  end

  always_comb begin
    play_len = PLAY_LEN;
    gap_len  = GAP_LEN;
    case (tempo_q)
      2'b01: begin
        play_len = PLAY_FAST;
        gap_len  = GAP_FAST;
      end
      2'b10: begin
        play_len = PLAY_SLOW;
        gap_len  = GAP_SLOW;
      end
      default: ;
    endcase
  end
`else
  assign play_len = PLAY_LEN;
  assign gap_len  = GAP_LEN;
`endif

  // Pitch tables folded to half-period constants.
  logic [TONE_W-1:0] half_low [7];
  logic [TONE_W-1:0] half_med [7];
  logic [TONE_W-1:0] half_high [7];

  for (genvar i = 0; i < 7; i++) begin : g_half
    assign half_low[i]  = half_period(CLK_FREQ, FREQ_LOW[i]);
    assign half_med[i]  = half_period(CLK_FREQ, FREQ_MED[i]);
    assign half_high[i] = half_period(CLK_FREQ, FREQ_HIGH[i]);
  end

  // Decode works off the registered note, never the raw ROM word.
  logic [NIB_W-1:0]  sel_nib;
  octave_e           sel_oct;
  logic              rest;
  logic [2:0]        degree;
  logic [TONE_W-1:0] tone_half;

  always_comb begin
    sel_nib = note_code_q[LOW_LSB +: NIB_W];
    sel_oct = OCT_LOW;
    if (note_code_q[HIGH_LSB +: NIB_W] != '0) begin
      sel_nib = note_code_q[HIGH_LSB +: NIB_W];
      sel_oct = OCT_HIGH;
    end else if (note_code_q[MED_LSB +: NIB_W] != '0) begin
      sel_nib = note_code_q[MED_LSB +: NIB_W];
      sel_oct = OCT_MED;
    end
    rest   = (sel_nib == '0) || sel_nib[3];
    degree = rest ? 3'd0 : sel_nib[2:0] - 3'd1;
    case (sel_oct)
      OCT_HIGH: tone_half = half_high[degree];
      OCT_MED:  tone_half = half_med[degree];
      default:  tone_half = half_low[degree];
    endcase
  end

  logic tone_en, tone_clr, tone_next;

  tone_gen u_tone (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (tone_en),
    .clr    (tone_clr),
    .half   (tone_half),
    .buzzer (tone_next)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rom_addr_d  = rom_addr_q;
    note_code_d = note_code_q;
    tone_en     = 1'b0;
    // Outside PLAY the tone restarts from phase zero, so each note begins low.
    tone_clr    = (state_q != ST_PLAY) || stop;

    if (stop) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      rom_addr_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d    = ST_LOAD;
            cnt_d      = '0;
            rom_addr_d = '0;
          end
        end
        ST_LOAD: begin
          if (!pause) begin
            note_code_d = rom_data;
            cnt_d       = '0;
            state_d     = ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (!pause) begin
            tone_en = !rest;
            if (cnt_q == play_len - CNT_W'(1)) begin
              cnt_d   = '0;
              state_d = ST_GAP;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_GAP: begin
          if (!pause) begin
            if (cnt_q == gap_len - CNT_W'(1)) begin
              cnt_d = '0;
              if (rom_addr_q < LAST_ADDR) begin
                rom_addr_d = rom_addr_q + ADDR_WIDTH'(1);
                state_d    = ST_LOAD;
              end else if (loop_en) begin
                rom_addr_d = '0;
                state_d    = ST_LOAD;
              end else begin
                state_d = ST_FINISH;
              end
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_FINISH: begin
          state_d    = ST_IDLE;
          rom_addr_d = '0;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    buzzer_d = tone_next && (state_d == ST_PLAY) && !pause && !rest;
    busy_d   = (state_d != ST_IDLE);
    done_d   = (state_d == ST_FINISH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rom_addr_q  <= '0;
      note_code_q <= '0;
      buzzer_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rom_addr_q  <= rom_addr_d;
      note_code_q <= note_code_d;
      buzzer_q    <= buzzer_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign note_code = note_code_q;
  assign buzzer    = buzzer_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_music_player.sv
// Directed bench for music_player with a 3-entry behavioural score ROM,
// 1 MHz clock rate, 10000-cycle beats and 1000-cycle gaps.
module tb_music_player;

  localparam int CLK_FREQ  = 1_000_000;
  localparam int BEAT      = 10000;
  localparam int GAP       = 1000;
  localparam int PLAY      = BEAT - GAP;
  localparam int DEPTH     = 3;
  localparam int AW        = 7;
  localparam int RW        = 12;
  localparam int PAUSE_LEN = 3000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          pause = 1'b0;
  logic          loop_en = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [RW-1:0] rom_data;
  logic [RW-1:0] note_code;
  logic          buzzer;
  logic          busy;
  logic          done;

  logic [RW-1:0] rom_mem [4];
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rom_data = rom_mem[rom_addr[1:0]];

  music_player #(
    .CLK_FREQ    (CLK_FREQ),
    .BEAT_CYCLES (BEAT),
    .GAP_CYCLES  (GAP),
    .ROM_DEPTH   (DEPTH),
    .ADDR_WIDTH  (AW),
    .ROM_WIDTH   (RW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .loop_en   (loop_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .note_code (note_code),
    .buzzer    (buzzer),
    .busy      (busy),
    .done      (done)
  );

  // Plays one slot starting from its LOAD cycle. Expected buzzer at PLAY
  // cycle p is floor((p-1)/half) mod 2, zero in the gap and for rests.
  task automatic play_slot(input int addr, input logic [RW-1:0] note, input int half,
                           input int pause_at, input logic start_level, output int load_cyc);
    int   p;
    int   bad;
    int   bad_p;
    logic bad_b;
    logic bad_exp;
    logic exp_b;
    bad = 0;
    bad_p = 0;
    bad_b = 1'b0;
    bad_exp = 1'b0;
    @(negedge clk);
    start = start_level;
    load_cyc = cyc;
    compared++;
    if (rom_addr !== AW'(addr) || busy !== 1'b1 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL load_addr%0d: rom_addr=%0d busy=%b done=%b, want rom_addr=%0d busy=1 done=0",
               addr, rom_addr, busy, done, addr);
    end
    p = 0;
    while (p < BEAT) begin
      if (pause_at != 0 && p == pause_at) begin
        pause = 1'b1;
        repeat (PAUSE_LEN) begin
          @(negedge clk);
          if (buzzer !== 1'b0 || rom_addr !== AW'(addr) || busy !== 1'b1) begin
            if (bad == 0) begin
              bad_p = p;
              bad_b = buzzer;
              bad_exp = 1'b0;
            end
            bad++;
          end
        end
        pause = 1'b0;
      end
      @(negedge clk);
      p++;
      exp_b = (half != 0 && p <= PLAY) ? (((p - 1) / half) % 2 == 1) : 1'b0;
      if (p == 1) begin
        compared++;
        if (note_code !== note) begin
          mismatched++;
          $display("FAIL note_addr%0d: note_code=%h, want %h", addr, note_code, note);
        end
      end
      if (buzzer !== exp_b || rom_addr !== AW'(addr) || busy !== 1'b1 || done !== 1'b0) begin
        if (bad == 0) begin
          bad_p = p;
          bad_b = buzzer;
          bad_exp = exp_b;
        end
        bad++;
      end
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("FAIL slot_addr%0d_trace: %0d bad cycles, first at play cycle %0d buzzer=%b want %b (rom_addr=%0d busy=%b done=%b)",
               addr, bad, bad_p, bad_b, bad_exp, rom_addr, busy, done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
    compared++;
    if (done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b want 0", done); end
    compared++;
    if (buzzer !== 1'b0) begin mismatched++; $display("FAIL reset_buzzer: got %b want 0", buzzer); end
    compared++;
    if (rom_addr !== '0) begin mismatched++; $display("FAIL reset_addr: got %0d want 0", rom_addr); end
    compared++;
    if (note_code !== '0) begin mismatched++; $display("FAIL reset_note: got %h want 000", note_code); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("FAIL post_reset_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_start_with_stop();
    start = 1'b1;
    stop = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if (busy !== 1'b0 || rom_addr !== '0 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL start_stop_idle: busy=%b rom_addr=%0d done=%b, want 0 0 0", busy, rom_addr, done);
    end
    start = 1'b0;
    stop = 1'b0;
    @(negedge clk);
  endtask

  // Lap 1 loops: tones for 001 and 010 (with a pause), rest for 000, then wrap.
  task automatic test_loop_pause();
    int lc;
    loop_en = 1'b1;
    start = 1'b1;
    play_slot(0, 12'h001, 1908, 0, 1'b0, lc);
    play_slot(1, 12'h010, 956, 3000, 1'b0, lc);
    play_slot(2, 12'h000, 0, 0, 1'b0, lc);
  endtask

  // Lap 2: start held while busy, 009 rest, then a single done pulse.
  task automatic test_full_pass();
    int c0;
    int lc;
    rom_mem[2] = 12'h009;
    play_slot(0, 12'h001, 1908, 0, 1'b1, c0);
    loop_en = 1'b0;
    play_slot(1, 12'h010, 956, 0, 1'b0, lc);
    play_slot(2, 12'h009, 0, 0, 1'b0, lc);
    @(negedge clk);
    compared++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL finish_pulse: done=%b busy=%b, want 1 1", done, busy);
    end
    compared++;
    if (cyc - c0 + 1 != DEPTH * (BEAT + 1) + 1) begin
      mismatched++;
      $display("FAIL pass_length: got %0d cycles want %0d", cyc - c0 + 1, DEPTH * (BEAT + 1) + 1);
    end
    @(negedge clk);
    compared++;
    if (done !== 1'b0 || busy !== 1'b0 || rom_addr !== '0) begin
      mismatched++;
      $display("FAIL after_finish: done=%b busy=%b rom_addr=%0d, want 0 0 0", done, busy, rom_addr);
    end
  endtask

  task automatic test_stop_in_gap();
    int bad;
    bad = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9500) @(negedge clk);
    compared++;
    if (busy !== 1'b1 || buzzer !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_gap: busy=%b buzzer=%b, want 1 0", busy, buzzer);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    compared++;
    if (busy !== 1'b0 || rom_addr !== '0 || buzzer !== 1'b0 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL stop_gap: busy=%b rom_addr=%0d buzzer=%b done=%b, want 0 0 0 0",
               busy, rom_addr, buzzer, done);
    end
    repeat (5) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) bad++;
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("FAIL stop_stays_idle: %0d cycles busy/done set, want 0", bad);
    end
  endtask

  initial begin
    rom_mem[0] = 12'h001;
    rom_mem[1] = 12'h010;
    rom_mem[2] = 12'h000;
    rom_mem[3] = 12'h000;
    test_reset();
    test_start_with_stop();
    test_loop_pause();
    test_full_pass();
    test_stop_in_gap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
